// File: rtl/coax_line_ctrl.sv
// Half-duplex line scheduler for the coax interface: arbitrates rx/tx on the shared line,
// holds the receiver in reset across transmit and turnaround, frames rx words, times out replies.
module coax_line_ctrl #(
  parameter int unsigned CLOCKS_PER_BIT  = 8,
  parameter int unsigned TURNAROUND_BITS = 2,
  parameter int unsigned RESPONSE_BITS   = 64,
  parameter int unsigned TX_START_BITS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active_i,
  input  logic       rx_error_i,
  input  logic       rx_strobe_i,
  input  logic [9:0] rx_data_i,
  output logic       rx_reset_o,
  input  logic       tx_req_i,
  input  logic       expect_response_i,
  output logic       tx_grant_o,
  input  logic       tx_active_i,
  output logic       word_valid_o,
  output logic [9:0] word_o,
  output logic       word_error_o,
  output logic       frame_done_o,
  output logic [7:0] frame_len_o,
  output logic       timeout_o
);

  localparam int unsigned WORD_W       = 10;
  localparam int unsigned LEN_W        = 8;
  localparam int unsigned TX_START_CYC = TX_START_BITS * CLOCKS_PER_BIT;
  localparam int unsigned TURN_CYC     = TURNAROUND_BITS * CLOCKS_PER_BIT;
  localparam int unsigned RESP_CYC     = RESPONSE_BITS * CLOCKS_PER_BIT;
  localparam int unsigned MAX_AB       = (TX_START_CYC > TURN_CYC) ? TX_START_CYC : TURN_CYC;
  localparam int unsigned MAX_CYC      = (MAX_AB > RESP_CYC) ? MAX_AB : RESP_CYC;
  localparam int unsigned TIMER_W      = $clog2(MAX_CYC + 1);
  localparam int unsigned TIMER_MAX    = (1 << TIMER_W) - 1;
  localparam int unsigned LEN_MAX      = (1 << LEN_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_RECOVER,
    S_GRANT,
    S_TRANSMIT,
    S_BLANK,
    S_RESP_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                expect_q, expect_d;
  logic                seen_q, seen_d;
  logic                rx_reset_q, rx_reset_d;
  logic                tx_grant_q, tx_grant_d;
  logic                word_valid_q, word_valid_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                word_error_q, word_error_d;
  logic                frame_done_q, frame_done_d;
  logic [LEN_W-1:0]    frame_len_q, frame_len_d;
  logic                timeout_q, timeout_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      expect_q     <= 1'b0;
      seen_q       <= 1'b0;
      rx_reset_q   <= 1'b1;
      tx_grant_q   <= 1'b0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      word_error_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      expect_q     <= expect_d;
      seen_q       <= seen_d;
      rx_reset_q   <= rx_reset_d;
      tx_grant_q   <= tx_grant_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      word_error_q <= word_error_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    expect_d     = expect_q;
    seen_d       = seen_q;
    tx_grant_d   = 1'b0;
    word_valid_d = 1'b0;
    word_d       = word_q;
    word_error_d = word_error_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_error_i) begin
          state_d = S_RECOVER;
        end else if (rx_active_i) begin
          state_d = S_RECEIVE;
          count_d = '0;
        end else if (tx_req_i) begin
          state_d    = S_GRANT;
          expect_d   = expect_response_i;
          tx_grant_d = 1'b1;
        end
      end

      S_RECEIVE: begin
        if (rx_error_i) begin
          word_valid_d = 1'b1;
          word_d       = rx_data_i;
          word_error_d = 1'b1;
          state_d      = S_RECOVER;
        end else begin
          if (rx_strobe_i) begin
            word_valid_d = 1'b1;
            word_d       = rx_data_i;
            word_error_d = 1'b0;
            if (count_q != LEN_W'(LEN_MAX)) begin
              count_d = LEN_W'(count_q + LEN_W'(1));
            end
          end
          // A strobe coinciding with the end of frame is still counted
          if (!rx_active_i) begin
            frame_done_d = 1'b1;
            frame_len_d  = count_d;
            state_d      = S_IDLE;
          end
        end
      end

      S_RECOVER: state_d = S_IDLE;

      S_GRANT: begin
        seen_d  = 1'b0;
        state_d = S_TRANSMIT;
      end

      S_TRANSMIT: begin
        if (tx_active_i) begin
          seen_d = 1'b1;
        end else if (seen_q || (timer_q == TIMER_W'(TX_START_CYC - 1))) begin
          state_d = S_BLANK;
        end
      end

      S_BLANK: begin
        if (timer_q == TIMER_W'(TURN_CYC - 1)) begin
          state_d = expect_q ? S_RESP_WAIT : S_IDLE;
        end
      end

      S_RESP_WAIT: begin
        if (rx_error_i) begin
          state_d  = S_RECOVER;
          expect_d = 1'b0;
        end else if (rx_active_i) begin
          state_d  = S_RECEIVE;
          count_d  = '0;
          expect_d = 1'b0;
        end else if (timer_q == TIMER_W'(RESP_CYC - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          expect_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    rx_reset_d = (state_d == S_RECOVER) || (state_d == S_GRANT) ||
                 (state_d == S_TRANSMIT) || (state_d == S_BLANK);

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TIMER_W'(TIMER_MAX)) begin
      timer_d = TIMER_W'(timer_q + TIMER_W'(1));
    end else begin
      timer_d = timer_q;
    end
  end

  assign rx_reset_o   = rx_reset_q;
  assign tx_grant_o   = tx_grant_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign word_error_o = word_error_q;
  assign frame_done_o = frame_done_q;
  assign frame_len_o  = frame_len_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_coax_line_ctrl.sv
// Directed self-checking bench for coax_line_ctrl at default parameters.
module tb_coax_line_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_active_i, rx_error_i, rx_strobe_i;
  logic [9:0] rx_data_i;
  logic       rx_reset_o;
  logic       tx_req_i, expect_response_i, tx_active_i;
  logic       tx_grant_o, word_valid_o, word_error_o, frame_done_o, timeout_o;
  logic [9:0] word_o;
  logic [7:0] frame_len_o;

  int n_tests = 0;
  int n_fail  = 0;

  coax_line_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .rx_active_i       (rx_active_i),
    .rx_error_i        (rx_error_i),
    .rx_strobe_i       (rx_strobe_i),
    .rx_data_i         (rx_data_i),
    .rx_reset_o        (rx_reset_o),
    .tx_req_i          (tx_req_i),
    .expect_response_i (expect_response_i),
    .tx_grant_o        (tx_grant_o),
    .tx_active_i       (tx_active_i),
    .word_valid_o      (word_valid_o),
    .word_o            (word_o),
    .word_error_o      (word_error_o),
    .frame_done_o      (frame_done_o),
    .frame_len_o       (frame_len_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_word(input logic [9:0] d);
    rx_strobe_i = 1'b1;
    rx_data_i   = d;
    step();
    rx_strobe_i = 1'b0;
  endtask

  // Counts cycles rx_reset stays high, starting with the current sample
  task automatic count_rx_reset_high(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!rx_reset_o) break;
      n++;
      step();
    end
  endtask

  logic [9:0] words [3];
  int n, hits;

  initial begin
    words[0] = 10'h2A5; words[1] = 10'h001; words[2] = 10'h3FF;
    reset = 1'b1;
    rx_active_i = 0; rx_error_i = 0; rx_strobe_i = 0; rx_data_i = '0;
    tx_req_i = 0; expect_response_i = 0; tx_active_i = 0;
    step(); step();
    check("reset_rx_reset", rx_reset_o, 1);
    check("reset_outs", {tx_grant_o, word_valid_o, frame_done_o, timeout_o, word_error_o}, 0);
    check("reset_len", frame_len_o, 0);
    reset = 1'b0;
    step();
    check("idle_rx_reset", rx_reset_o, 0);

    // 1: three-word frame
    rx_active_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      strobe_word(words[i]);
      check("t1_valid", word_valid_o, 1);
      check("t1_word", word_o, words[i]);
      check("t1_err", word_error_o, 0);
    end
    rx_active_i = 1'b0;
    step();
    check("t1_done", frame_done_o, 1);
    check("t1_len", frame_len_o, 3);
    check("t1_novalid", word_valid_o, 0);
    step();
    check("t1_done_pulse", frame_done_o, 0);

    // 2: error mid-frame
    rx_active_i = 1'b1;
    step();
    strobe_word(10'h155);
    rx_error_i = 1'b1; rx_data_i = 10'h002;
    step();
    rx_error_i = 1'b0; rx_active_i = 1'b0;
    check("t2_valid", word_valid_o, 1);
    check("t2_word", word_o, 10'h002);
    check("t2_err", word_error_o, 1);
    check("t2_nodone", frame_done_o, 0);
    check("t2_rxrst", rx_reset_o, 1);
    step();
    check("t2_rxrst_1cyc", rx_reset_o, 0);
    check("t2_nodone2", frame_done_o, 0);

    // 3: transmit without response
    tx_req_i = 1'b1; expect_response_i = 1'b0;
    step();
    tx_req_i = 1'b0;
    check("t3_grant", tx_grant_o, 1);
    check("t3_grant_rxrst", rx_reset_o, 1);
    step();
    check("t3_grant_pulse", tx_grant_o, 0);
    tx_active_i = 1'b1;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!rx_reset_o) hits++;
    end
    check("t3_rxrst_during_tx", hits, 0);
    tx_active_i = 1'b0;
    step();
    count_rx_reset_high(n);
    check("t3_blank_len", n, 16);
    check("t3_no_timeout", timeout_o, 0);

    // 4a: expect response, none arrives
    tx_req_i = 1'b1; expect_response_i = 1'b1;
    step();
    tx_req_i = 1'b0; expect_response_i = 1'b0;
    tx_active_i = 1'b1;
    repeat (5) step();
    tx_active_i = 1'b0;
    step();
    count_rx_reset_high(n);
    check("t4_blank_len", n, 16);
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (timeout_o) begin n = i; break; end
    end
    check("t4_timeout_at", n, 512);
    step();
    check("t4_timeout_pulse", timeout_o, 0);

    // 4b: response arrives at cycle 100
    tx_req_i = 1'b1; expect_response_i = 1'b1;
    step();
    tx_req_i = 1'b0; expect_response_i = 1'b0;
    tx_active_i = 1'b1;
    repeat (5) step();
    tx_active_i = 1'b0;
    step();
    count_rx_reset_high(n);
    repeat (99) step();
    rx_active_i = 1'b1;
    hits = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (timeout_o) hits++;
    end
    check("t4_no_timeout", hits, 0);
    check("t4_rx_reset_low", rx_reset_o, 0);
    rx_active_i = 1'b0;
    step();
    check("t4_done", frame_done_o, 1);
    check("t4_len", frame_len_o, 0);

    // 5: receive wins over simultaneous tx_req
    rx_active_i = 1'b1; tx_req_i = 1'b1;
    step();
    check("t5_no_grant", tx_grant_o, 0);
    strobe_word(10'h0F0);
    check("t5_valid", word_valid_o, 1);
    rx_active_i = 1'b0;
    step();
    check("t5_done", frame_done_o, 1);
    check("t5_len", frame_len_o, 1);
    check("t5_no_grant2", tx_grant_o, 0);
    step();
    check("t5_grant_after", tx_grant_o, 1);
    tx_req_i = 1'b0;
    count_rx_reset_high(n);
    check("t5_tx_start_timeout", n, 33);

    // 6: reset during TRANSMIT, GRANT, RECEIVE; then saturating frame
    tx_req_i = 1'b1;
    step();
    tx_req_i = 1'b0; tx_active_i = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("t6_tx_rxrst", rx_reset_o, 1);
    check("t6_tx_outs", {tx_grant_o, word_valid_o, frame_done_o}, 0);
    reset = 1'b0; tx_active_i = 1'b0;
    step();
    check("t6_tx_idle", rx_reset_o, 0);

    tx_req_i = 1'b1; reset = 1'b1;
    step();
    check("t6_grant_abandoned", tx_grant_o, 0);
    reset = 1'b0; tx_req_i = 1'b0;
    step();
    check("t6_no_late_grant", tx_grant_o, 0);

    rx_active_i = 1'b1;
    step();
    rx_strobe_i = 1'b1; rx_data_i = 10'h0AA; rx_active_i = 1'b0; reset = 1'b1;
    step();
    rx_strobe_i = 1'b0; reset = 1'b0;
    check("t6_rx_rxrst", rx_reset_o, 1);
    check("t6_rx_outs", {word_valid_o, frame_done_o, tx_grant_o}, 0);
    step();
    check("t6_rx_idle", rx_reset_o, 0);

    rx_active_i = 1'b1;
    step();
    for (int i = 0; i < 300; i++) strobe_word(10'(i));
    check("t6_last_word", word_o, 10'd299);
    rx_active_i = 1'b0;
    step();
    check("t6_sat_done", frame_done_o, 1);
    check("t6_sat_len", frame_len_o, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
